// File: rtl/huff_dist_decode.sv
// Serial canonical-Huffman decoder for DEFLATE distance symbols.
// Walks the code space one bit at a time against the builder's per-length counts.
module huff_dist_decode #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tree_ready,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [3:0] len_out,
  output logic [7:0] code_out,
  input  logic [3:0] dist_count,
  input  logic [3:0] dist_symb,
  output logic [3:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       err
);

  localparam logic [3:0] MaxLen = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StBit,
    StCheck,
    StOut,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  code_q, code_d;
  logic [8:0]  first_q, first_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  sym_q, sym_d;
  logic [3:0]  len_hold_q, len_hold_d;
  logic [7:0]  code_hold_q, code_hold_d;

  logic [8:0]  count_ext;
  logic [8:0]  code_off;
  logic        match;

  // Candidate lies inside the length-L block [first, first + count).
  assign count_ext = {5'd0, dist_count};
  assign code_off  = code_q - first_q;
  assign match     = (code_q >= first_q) && (code_off < count_ext);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    first_d     = first_q;
    len_d       = len_q;
    sym_d       = sym_q;
    len_hold_d  = len_hold_q;
    code_hold_d = code_hold_q;

    unique case (state_q)
      StIdle: begin
        code_d  = '0;
        first_d = '0;
        len_d   = '0;
        sym_d   = '0;
        if (tree_ready) begin
          state_d = StBit;
        end
      end

      StBit: begin
        if (bit_valid) begin
          code_d  = {code_q[7:0], bit_in};
          len_d   = len_q + 4'd1;
          state_d = StCheck;
        end
      end

      StCheck: begin
        len_hold_d  = len_q;
        code_hold_d = code_q[7:0];
        if (match) begin
          sym_d   = dist_symb;
          state_d = StOut;
        end else if (len_q == MaxLen) begin
          state_d = StErr;
        end else begin
          // Canonical rule: next length starts at (first + count) * 2.
          first_d = (first_q + count_ext) << 1;
          state_d = StBit;
        end
      end

      StOut: begin
        if (sym_ready) begin
          code_d  = '0;
          first_d = '0;
          len_d   = '0;
          state_d = StBit;
        end
      end

      StErr: begin
        state_d = StErr;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      code_q      <= '0;
      first_q     <= '0;
      len_q       <= '0;
      sym_q       <= '0;
      len_hold_q  <= '0;
      code_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      first_q     <= first_d;
      len_q       <= len_d;
      sym_q       <= sym_d;
      len_hold_q  <= len_hold_d;
      code_hold_q <= code_hold_d;
    end
  end

  // Lookup address is live during CHECK and frozen at its last value otherwise.
  assign len_out   = (state_q == StCheck) ? len_q : len_hold_q;
  assign code_out  = (state_q == StCheck) ? code_q[7:0] : code_hold_q;
  assign bit_ready = (state_q == StBit);
  assign sym_valid = (state_q == StOut);
  assign sym_out   = sym_q;
  assign err       = (state_q == StErr);

endmodule

// File: tb/tb_huff_dist_decode.sv
// Directed bench for huff_dist_decode with a small combinational builder model.
module tb_huff_dist_decode;

  logic       clk;
  logic       rst;
  logic       tree_ready;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [3:0] len_out;
  logic [7:0] code_out;
  logic [3:0] dist_count;
  logic [3:0] dist_symb;
  logic [3:0] sym_out;
  logic       sym_valid;
  logic       sym_ready;
  logic       err;

  logic       table_en;
  int         nvec;
  int         nerr;
  int         idx;
  int         k;
  int         seen_valid;

  logic       stream_bits [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] stream_exp  [4] = '{4'd0, 4'd1, 4'd3, 4'd2};

  huff_dist_decode #(.MAX_LEN(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tree_ready (tree_ready),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .len_out    (len_out),
    .code_out   (code_out),
    .dist_count (dist_count),
    .dist_symb  (dist_symb),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builder model: lengths sym0=1, sym1=2, sym2=3, sym3=3 -> codes 0, 10, 110, 111.
  always_comb begin
    dist_count = 4'd0;
    dist_symb  = 4'd0;
    if (table_en) begin
      unique case (len_out)
        4'd1:    dist_count = 4'd1;
        4'd2:    dist_count = 4'd1;
        4'd3:    dist_count = 4'd2;
        default: dist_count = 4'd0;
      endcase
      if (len_out == 4'd2 && code_out == 8'd2) dist_symb = 4'd1;
      if (len_out == 4'd3 && code_out == 8'd6) dist_symb = 4'd2;
      if (len_out == 4'd3 && code_out == 8'd7) dist_symb = 4'd3;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bit_in    = b;
    bit_valid = 1'b1;
    while (!bit_ready && n < 50) begin
      step();
      n++;
    end
    chk("bit_wait", 32'(bit_ready), 32'd1);
    step();
    bit_valid = 1'b0;
  endtask

  initial begin
    nvec       = 0;
    nerr       = 0;
    rst        = 1'b1;
    tree_ready = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    sym_ready  = 1'b0;
    table_en   = 1'b1;
    #1;
    chk("rst_bit_ready", 32'(bit_ready), 32'd0);
    chk("rst_sym_valid", 32'(sym_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sym_out", 32'(sym_out), 32'd0);
    chk("rst_len_out", 32'(len_out), 32'd0);
    chk("rst_code_out", 32'(code_out), 32'd0);
    repeat (2) step();
    rst = 1'b0;

    // Start gating: bits offered without tree_ready are ignored.
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gate_bit_ready", 32'(bit_ready), 32'd0);
      chk("gate_len_out", 32'(len_out), 32'd0);
    end
    bit_valid  = 1'b0;
    tree_ready = 1'b1;
    step();
    tree_ready = 1'b0;
    chk("start_bit_ready", 32'(bit_ready), 32'd1);

    // Bits 1,1,0 held valid: CHECKs at cycles 1,3,5, sym_valid at cycle 6.
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    step();
    chk("c1_len", 32'(len_out), 32'd1);
    chk("c1_code", 32'(code_out), 32'd1);
    chk("c1_bit_ready", 32'(bit_ready), 32'd0);
    step();
    chk("c2_bit_ready", 32'(bit_ready), 32'd1);
    step();
    chk("c3_len", 32'(len_out), 32'd2);
    chk("c3_code", 32'(code_out), 32'd3);
    step();
    bit_in = 1'b0;
    step();
    chk("c5_len", 32'(len_out), 32'd3);
    chk("c5_code", 32'(code_out), 32'd6);
    chk("c5_sym_valid", 32'(sym_valid), 32'd0);
    step();
    chk("c6_sym_valid", 32'(sym_valid), 32'd1);
    chk("c6_sym_out", 32'(sym_out), 32'd2);

    // Backpressure: bit 0 waits while OUT is stalled.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sym_valid", 32'(sym_valid), 32'd1);
      chk("bp_sym_out", 32'(sym_out), 32'd2);
      chk("bp_bit_ready", 32'(bit_ready), 32'd0);
    end
    sym_ready = 1'b1;
    step();
    sym_ready = 1'b0;
    chk("hs_bit_ready", 32'(bit_ready), 32'd1);
    chk("hs_sym_valid", 32'(sym_valid), 32'd0);
    step();
    chk("s0_len", 32'(len_out), 32'd1);
    chk("s0_code", 32'(code_out), 32'd0);
    step();
    bit_valid = 1'b0;
    chk("s0_sym_valid", 32'(sym_valid), 32'd1);
    chk("s0_sym_out", 32'(sym_out), 32'd0);
    sym_ready = 1'b1;
    step();

    // Back-to-back stream 0,10,111,110 -> 0,1,3,2.
    idx = 0;
    k   = 0;
    for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
      if (sym_valid) begin
        chk("stream_sym", 32'(sym_out), 32'(stream_exp[k]));
        k++;
      end
      if (bit_ready && idx < 9) begin
        bit_in    = stream_bits[idx];
        bit_valid = 1'b1;
        idx++;
      end else begin
        bit_valid = 1'b0;
      end
      step();
    end
    bit_valid = 1'b0;
    chk("stream_count", 32'(k), 32'd4);
    chk("stream_bits_used", 32'(idx), 32'd9);
    sym_ready = 1'b0;

    // Reset after two bits of a three-bit code.
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_len", 32'(len_out), 32'd2);
    bit_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_bit_ready", 32'(bit_ready), 32'd0);
    chk("mid_rst_len_out", 32'(len_out), 32'd0);
    chk("mid_rst_code_out", 32'(code_out), 32'd0);
    chk("mid_rst_sym_out", 32'(sym_out), 32'd0);
    chk("mid_rst_sym_valid", 32'(sym_valid), 32'd0);
    #2;
    rst = 1'b0;
    step();
    chk("idle_bit_ready", 32'(bit_ready), 32'd0);
    tree_ready = 1'b1;
    step();
    tree_ready = 1'b0;
    send_bit(1'b1);
    chk("rr_code1", 32'(code_out), 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("rr_code3", 32'(code_out), 32'd7);
    step();
    chk("rr_sym_valid", 32'(sym_valid), 32'd1);
    chk("rr_sym_out", 32'(sym_out), 32'd3);
    sym_ready = 1'b1;
    step();
    sym_ready = 1'b0;

    // Empty table: eight unmatched bits end in sticky ERR.
    table_en   = 1'b0;
    seen_valid = 0;
    bit_in     = 1'b1;
    bit_valid  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (sym_valid) seen_valid++;
      if (i == 15) begin
        chk("err_early", 32'(err), 32'd0);
        chk("err_len8", 32'(len_out), 32'd8);
      end
      if (i >= 16) begin
        chk("err_set", 32'(err), 32'd1);
        chk("err_bit_ready", 32'(bit_ready), 32'd0);
      end
    end
    chk("err_no_valid", 32'(seen_valid), 32'd0);
    chk("err_code_hold", 32'(code_out), 32'hff);
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("err_cleared", 32'(err), 32'd0);
    #2;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
